// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: controller states and frame layout constants
package aes_stream_pkg;
  typedef enum logic [2:0] {IDLE, KEY, DATA, START, WAIT, SEND} state_t;
  localparam int CMD_DEC = 0;
  localparam int CMD_KEY = 1;
  localparam int AES_BLOCK_BYTES = 16;
endpackage

// File: rtl/aes_stream_ctrl_if.sv
// aes_stream_ctrl_if: inbound and outbound byte-stream handshakes
interface aes_stream_ctrl_if;
  logic [7:0] i_Byte;
  logic [7:0] o_Byte;
  logic i_fByteValid;
  logic o_fByteReady;
  logic o_fByteValid;
  logic i_fByteReady;
  modport slave (input i_Byte, i_fByteValid, i_fByteReady, output o_fByteReady, o_Byte, o_fByteValid);
  modport master (output i_Byte, i_fByteValid, i_fByteReady, input o_fByteReady, o_Byte, o_fByteValid);
endinterface

// File: rtl/aes_byte_shreg.sv
// aes_byte_shreg: 128-bit register with parallel load and byte-wide left shift
module aes_byte_shreg (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic         shift,
  input  logic [127:0] load_data,
  input  logic [7:0]   shift_in,
  output logic [127:0] q
);
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) q <= '0;
    else if (load) q <= load_data;
    else if (shift) q <= {q[119:0], shift_in};
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: frames a byte stream into key/data blocks for an AES core and streams the result back
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                   Clk,
  input  logic                   Rst,
  aes_stream_ctrl_if.slave       bus,
  output logic                   o_fStart,
  output logic                   o_fDec,
  output logic [127:0]           o_Data,
  output logic [127:0]           o_Key,
  input  logic [127:0]           i_Data,
  input  logic                   i_fDone,
  output logic                   o_fBusy,
  output logic                   o_fTimeout
);
  state_t st, nxt;
  logic [3:0] cnt;
  logic [7:0] wcnt;
  logic [127:0] res;
  logic acc, xfer, last, done;
  assign bus.o_fByteReady = st inside {IDLE, KEY, DATA};
  assign bus.o_fByteValid = st == SEND;
  assign bus.o_Byte = res[127:120];
  assign acc = bus.i_fByteValid && bus.o_fByteReady;
  assign xfer = st == SEND && bus.i_fByteReady;
  assign last = cnt == 4'(AES_BLOCK_BYTES - 1);
  assign done = st == WAIT && i_fDone;
  // a core result arriving on the final count beats the timeout
  assign o_fTimeout = st == WAIT && !i_fDone && wcnt == 8'(TIMEOUT - 1);
  assign o_fStart = st == START;
  assign o_fBusy = st != IDLE;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = acc ? (bus.i_Byte[CMD_KEY] ? KEY : DATA) : IDLE;
      KEY:     nxt = acc && last ? DATA : KEY;
      DATA:    nxt = acc && last ? START : DATA;
      START:   nxt = WAIT;
      WAIT:    nxt = done ? SEND : o_fTimeout ? IDLE : WAIT;
      SEND:    nxt = xfer && last ? IDLE : SEND;
      default: nxt = IDLE;
    endcase
  end
  // one byte counter serves KEY, DATA and SEND; it wraps to 0 at each block end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      st <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      o_fDec <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= st == IDLE ? '0 : (acc || xfer) ? cnt + 4'd1 : cnt;
      wcnt <= st == WAIT ? wcnt + 8'd1 : '0;
      if (st == IDLE && acc) o_fDec <= bus.i_Byte[CMD_DEC];
    end
  aes_byte_shreg u_key (
    .Clk(Clk), .Rst(Rst), .load(1'b0), .shift(st == KEY && acc),
    .load_data('0), .shift_in(bus.i_Byte), .q(o_Key)
  );
  aes_byte_shreg u_data (
    .Clk(Clk), .Rst(Rst), .load(1'b0), .shift(st == DATA && acc),
    .load_data('0), .shift_in(bus.i_Byte), .q(o_Data)
  );
  aes_byte_shreg u_res (
    .Clk(Clk), .Rst(Rst), .load(done), .shift(xfer),
    .load_data(i_Data), .shift_in(8'h00), .q(res)
  );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: scoreboard bench with FIPS-197 vectors and a table-lookup core stub
module tb_aes_stream_ctrl;
  localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  typedef struct {logic dec; logic [127:0] key; logic [127:0] data;} start_t;
  logic Clk = 0, Rst = 0;
  logic o_fStart, o_fDec, i_fDone, o_fBusy, o_fTimeout;
  logic [127:0] o_Data, o_Key, i_Data;
  aes_stream_ctrl_if bus();
  aes_stream_ctrl #(.TIMEOUT(255)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus), .o_fStart(o_fStart), .o_fDec(o_fDec),
    .o_Data(o_Data), .o_Key(o_Key), .i_Data(i_Data), .i_fDone(i_fDone),
    .o_fBusy(o_fBusy), .o_fTimeout(o_fTimeout)
  );
  always #5 Clk = ~Clk;
  start_t exp_start[$];
  start_t e;
  logic [7:0] exp_byte[$];
  int exp_tmo = 0, checks = 0, errors = 0, cyc = 0, start_cyc = 0, xfers = 0, core_dly = 3;
  bit core_en = 1, stall_en = 0, stalled = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced an event with nothing expected", name);
  endtask
  always @(posedge Clk) cyc++;
  always @(negedge Clk) if (Rst) begin
    if (o_fStart) begin
      start_cyc = cyc;
      if (exp_start.size() == 0) unexpected("unexpected_start");
      else begin
        e = exp_start.pop_front();
        chk("start_dec", 128'(o_fDec), 128'(e.dec));
        chk("start_key", o_Key, e.key);
        chk("start_data", o_Data, e.data);
      end
    end
    if (o_fTimeout) begin
      if (exp_tmo == 0) unexpected("unexpected_timeout");
      else begin
        exp_tmo--;
        chk("timeout_latency", 128'(cyc - start_cyc), 128'd255);
      end
    end
    if (bus.o_fByteValid) begin
      if (exp_byte.size() == 0) unexpected("unexpected_byte");
      else if (bus.i_fByteReady) begin
        chk("out_byte", 128'(bus.o_Byte), 128'(exp_byte.pop_front()));
        xfers++;
      end else chk("held_byte", 128'(bus.o_Byte), 128'(exp_byte[0]));
    end
  end
  initial forever begin
    @(negedge Clk);
    if (o_fStart && core_en) begin : core
      automatic logic [127:0] r = o_fDec ? ((o_Data == C && o_Key == K) ? P : '0)
                                         : ((o_Data == P && o_Key == K) ? C : '0);
      repeat (core_dly) @(posedge Clk);
      #1 i_Data = r;
      i_fDone = 1;
      @(posedge Clk);
      #1 i_fDone = 0;
    end
  end
  initial forever begin
    @(posedge Clk);
    #1;
    if (stall_en && !stalled && xfers == 3) begin
      bus.i_fByteReady = 0;
      repeat (5) @(posedge Clk);
      #1 bus.i_fByteReady = 1;
      stalled = 1;
    end
  end
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge Clk); #1; end
    bus.i_Byte = b;
    bus.i_fByteValid = 1;
    while (!bus.o_fByteReady && n < 1000) begin @(posedge Clk); #1; n++; end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_ready: o_fByteReady stayed %b, required 1", bus.o_fByteReady);
    end
    @(posedge Clk);
    #1 bus.i_fByteValid = 0;
  endtask
  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] key, input logic [127:0] data, input int maxgap);
    send_byte(cmd, $urandom_range(maxgap, 0));
    if (cmd[1]) for (int i = 0; i < 16; i++) send_byte(key[127-8*i -: 8], $urandom_range(maxgap, 0));
    for (int i = 0; i < 16; i++) send_byte(data[127-8*i -: 8], $urandom_range(maxgap, 0));
  endtask
  task automatic push_block(input logic [127:0] v);
    for (int i = 0; i < 16; i++) exp_byte.push_back(v[127-8*i -: 8]);
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while ((o_fBusy || exp_byte.size() != 0 || exp_start.size() != 0 || exp_tmo != 0) && n < 2000) begin
      @(posedge Clk); #1; n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s: still busy=%b with %0d bytes, %0d starts, %0d timeouts outstanding, required none",
               name, o_fBusy, exp_byte.size(), exp_start.size(), exp_tmo);
    end
  endtask
  task automatic chk_idle(input string name, input bit rst_vals);
    @(negedge Clk);
    chk({name, "_busy"}, 128'(o_fBusy), 128'd0);
    chk({name, "_ready"}, 128'(bus.o_fByteReady), 128'd1);
    chk({name, "_valid"}, 128'(bus.o_fByteValid), 128'd0);
    chk({name, "_start"}, 128'(o_fStart), 128'd0);
    chk({name, "_tmo"}, 128'(o_fTimeout), 128'd0);
    if (rst_vals) begin
      chk({name, "_dec"}, 128'(o_fDec), 128'd0);
      chk({name, "_data"}, o_Data, 128'd0);
      chk({name, "_key"}, o_Key, 128'd0);
      chk({name, "_byte"}, 128'(bus.o_Byte), 128'd0);
    end
    @(posedge Clk);
    #1;
  endtask
  initial begin
    bus.i_Byte = 0;
    bus.i_fByteValid = 0;
    bus.i_fByteReady = 1;
    i_fDone = 0;
    i_Data = 0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1;
    chk_idle("reset", 1);
    exp_start.push_back('{1'b0, K, P});
    push_block(C);
    send_frame(8'h02, K, P, 0);
    wait_done("encrypt");
    exp_start.push_back('{1'b1, K, C});
    push_block(P);
    core_dly = 255;
    send_frame(8'h01, '0, C, 0);
    wait_done("decrypt_done_on_timeout_cycle");
    core_dly = 3;
    i_Data = C;
    i_fDone = 1;
    @(posedge Clk);
    #1 i_fDone = 0;
    chk_idle("done_in_idle", 0);
    core_en = 0;
    exp_start.push_back('{1'b0, K, P});
    exp_tmo = 1;
    send_frame(8'hfc, '0, P, 0);
    wait_done("timeout");
    chk_idle("after_timeout", 0);
    core_en = 1;
    xfers = 0;
    stall_en = 1;
    exp_start.push_back('{1'b0, K, P});
    push_block(C);
    send_frame(8'h00, '0, P, 0);
    wait_done("stall");
    chk("stall_happened", 128'(stalled), 128'd1);
    stall_en = 0;
    send_byte(8'h02, 0);
    for (int i = 0; i < 16; i++) send_byte(K[127-8*i -: 8], 0);
    for (int i = 0; i < 7; i++) send_byte(P[127-8*i -: 8], 0);
    Rst = 0;
    @(negedge Clk);
    chk("midreset_busy", 128'(o_fBusy), 128'd0);
    chk("midreset_key", o_Key, 128'd0);
    chk("midreset_data", o_Data, 128'd0);
    @(posedge Clk);
    #1 Rst = 1;
    chk_idle("after_midreset", 1);
    exp_start.push_back('{1'b0, K, P});
    push_block(C);
    send_frame(8'h02, K, P, 0);
    wait_done("post_reset_frame");
    exp_start.push_back('{1'b0, K, P});
    push_block(C);
    send_frame(8'h02, K, P, 3);
    wait_done("gapped_frame");
    chk_idle("final", 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
